// File: rtl/line_rotator_pp.sv
// Ping-pong line rotator: buffers one BT.656 line while replaying the previous
// one, cyclically rotating only its active-video words by a per-line offset.
module line_rotator_pp #(
   parameter int DATA_WIDTH    = 10,
   parameter int LINE_WORDS    = 1716,
   parameter int ACTIVE_OFFSET = 276,
   parameter int ACTIVE_WORDS  = 1440,
   parameter int CUT_WIDTH     = 8,
   parameter int CUT_STEP      = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  H,
   input  logic                  V,
   input  logic [CUT_WIDTH-1:0]  raw_cut_position,
   input  logic                  mode,
   input  logic                  enable,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  length_err
);

   localparam int CNT_W = $clog2(LINE_WORDS + 1);
   localparam logic [CNT_W-1:0] LAST       = CNT_W'(LINE_WORDS - 1);
   localparam logic [CNT_W-1:0] A_OFF      = CNT_W'(ACTIVE_OFFSET);
   localparam logic [CNT_W-1:0] A_OFF_M1   = CNT_W'(ACTIVE_OFFSET - 1);
   localparam logic [CNT_W-1:0] A_WORDS    = CNT_W'(ACTIVE_WORDS);

   // Offsets must fold into range with a single subtraction, and the
   // pointer preload needs at least one blanking word ahead of active video.
   if ((2**CUT_WIDTH - 1) * CUT_STEP >= 2 * ACTIVE_WORDS) begin : g_bad_cut
      $error("raw_cut_position range too large for single-subtract fold");
   end
   if (ACTIVE_OFFSET + ACTIVE_WORDS != LINE_WORDS || ACTIVE_OFFSET < 1) begin : g_bad_geom
      $error("line geometry inconsistent");
   end

   logic                  prev_h_reg;
   logic                  bank_sel_reg;
   logic                  started_reg;
   logic [CNT_W-1:0]      wr_cnt_reg, wr_cnt_next;
   logic                  full_reg, full_next;
   logic                  long_reg, long_next;
   logic                  cap_v_reg, cap_en_reg, cap_mode_reg;
   logic [CNT_W-1:0]      cap_off_reg;
   logic [CNT_W-1:0]      rd_cnt_reg, rd_cnt_next;
   logic [CNT_W-1:0]      rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0]      rd_off_reg, rd_off_use;
   logic                  rd_bank_reg;
   logic                  vld_reg;

   logic                  line_start;
   logic                  line_bad;
   logic                  wr_bank, rd_bank;
   logic [CNT_W-1:0]      wr_addr, rd_addr, rd_k;
   logic [31:0]           prod;
   logic [CNT_W-1:0]      off_new, eff_off;

   // Line-start detection, offset folding, and write/read address generation.
   always_comb begin
      line_start  = H & ~prev_h_reg;
      wr_bank     = line_start ? ~bank_sel_reg : bank_sel_reg;
      rd_bank     = ~wr_bank;
      wr_addr     = line_start ? '0 : wr_cnt_reg;
      wr_cnt_next = line_start ? CNT_W'(1) : ((wr_cnt_reg == LAST) ? LAST : wr_cnt_reg + 1'b1);
      full_next   = full_reg;
      long_next   = long_reg;
      if (line_start) begin
         full_next = 1'b0;
         long_next = 1'b0;
      end else if (wr_cnt_reg == LAST) begin
         full_next = 1'b1;
         long_next = long_reg | full_reg;
      end

      prod    = 32'(raw_cut_position) * 32'(CUT_STEP);
      off_new = (prod >= 32'(ACTIVE_WORDS)) ? CNT_W'(prod - 32'(ACTIVE_WORDS)) : CNT_W'(prod);

      // A line finishing short or long is replayed unrotated.
      line_bad = started_reg & (~full_reg | long_reg);
      eff_off  = '0;
      if (!(cap_v_reg || !cap_en_reg || line_bad)) begin
         if (cap_mode_reg) eff_off = (cap_off_reg == '0) ? '0 : A_WORDS - cap_off_reg;
         else              eff_off = cap_off_reg;
      end
      rd_off_use = line_start ? eff_off : rd_off_reg;

      rd_k        = line_start ? '0 : rd_cnt_reg;
      rd_cnt_next = (rd_k == LAST) ? LAST : rd_k + 1'b1;
      rd_addr     = (rd_k < A_OFF) ? rd_k : rd_ptr_reg;
      if (rd_k == A_OFF_M1)     rd_ptr_next = A_OFF + rd_off_use;
      else if (rd_addr == LAST) rd_ptr_next = A_OFF;
      else                      rd_ptr_next = rd_addr + 1'b1;
   end

   // Two line banks with registered read; the bank not being written is read.
   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      localparam logic BANK_ID = 1'(gi);
      logic [DATA_WIDTH-1:0] mem [0:LINE_WORDS-1];
      logic [DATA_WIDTH-1:0] q_reg;
      // Write port for the line being captured, read port for the replay.
      always_ff @(posedge clk) begin
         if (wr_bank == BANK_ID) mem[wr_addr] <= data_in;
         q_reg <= mem[rd_addr];
      end
   end

   // Control state, per-line key capture and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_h_reg   <= 1'b0;
         bank_sel_reg <= 1'b0;
         started_reg  <= 1'b0;
         wr_cnt_reg   <= '0;
         full_reg     <= 1'b0;
         long_reg     <= 1'b0;
         cap_v_reg    <= 1'b0;
         cap_en_reg   <= 1'b0;
         cap_mode_reg <= 1'b0;
         cap_off_reg  <= '0;
         rd_cnt_reg   <= '0;
         rd_ptr_reg   <= '0;
         rd_off_reg   <= '0;
         rd_bank_reg  <= 1'b0;
         vld_reg      <= 1'b0;
         data_out     <= '0;
         data_valid   <= 1'b0;
         length_err   <= 1'b0;
      end else begin
         prev_h_reg  <= H;
         wr_cnt_reg  <= wr_cnt_next;
         full_reg    <= full_next;
         long_reg    <= long_next;
         rd_cnt_reg  <= rd_cnt_next;
         rd_ptr_reg  <= rd_ptr_next;
         rd_off_reg  <= rd_off_use;
         rd_bank_reg <= rd_bank;
         length_err  <= line_start & line_bad;
         if (line_start) begin
            bank_sel_reg <= ~bank_sel_reg;
            started_reg  <= 1'b1;
            cap_v_reg    <= V;
            cap_en_reg   <= enable;
            cap_mode_reg <= mode;
            cap_off_reg  <= off_new;
            if (started_reg) vld_reg <= 1'b1;
         end
         data_out   <= rd_bank_reg ? g_bank[1].q_reg : g_bank[0].q_reg;
         data_valid <= vld_reg;
      end
   end

endmodule

// File: tb/tb_line_rotator_pp.sv
// Bench for line_rotator_pp: directed vector table on ramp lines, a
// scramble->descramble chain with random keys, and length/reset sequences.
module tb_line_rotator_pp;

   localparam int DW  = 10;
   localparam int LW  = 1716;
   localparam int AO  = 276;
   localparam int AW  = 1440;
   localparam int CW  = 8;
   localparam int CS  = 4;
   localparam int HW  = 8;          // words per line with H held high
   localparam int LAT = LW + 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic          h = 1'b0, v = 1'b0, mode = 1'b0, en = 1'b0;
   logic [CW-1:0] raw = '0;
   logic [DW-1:0] data_out;
   logic          data_valid, length_err;

   logic          h_b = 1'b0, v_b = 1'b0, mode_b = 1'b0, en_b = 1'b0;
   logic [CW-1:0] raw_b = '0;
   logic [DW-1:0] out_b;
   logic          dv_b, le_b;

   always #5 clk = ~clk;

   line_rotator_pp dut (
      .clk(clk), .reset_n(reset_n), .data_in(data_in), .H(h), .V(v),
      .raw_cut_position(raw), .mode(mode), .enable(en),
      .data_out(data_out), .data_valid(data_valid), .length_err(length_err));

   line_rotator_pp u_desc (
      .clk(clk), .reset_n(reset_n), .data_in(data_out), .H(h_b), .V(v_b),
      .raw_cut_position(raw_b), .mode(mode_b), .enable(en_b),
      .data_out(out_b), .data_valid(dv_b), .length_err(le_b));

   typedef struct {bit v; int raw; bit mode; bit en;} key_t;
   typedef struct {int raw; bit mode; bit en; bit v; int k; int want; string name;} vec_t;
   typedef struct {int at; int want; string name;} probe_t;

   int checks = 0, errors = 0;
   int slot = 0;
   int le_count = 0;

   // reference model state
   logic [DW-1:0] mdl_buf [LW];
   int            mdl_n = 0, mdl_starts = 0, dv_from = -1;
   bit            mdl_started = 0, mdl_prev_h = 0;
   key_t          mdl_key, prev_key;
   logic [DW-1:0] exp_out [int];
   bit            exp_le [int];
   probe_t        probes [$];
   logic [DW-1:0] hist [int];
   int            chain_lo = -1, chain_hi = -1;
   bit            h_d1 = 0, h_d2 = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s at slot %0d: got %0d expected %0d", name, slot, got, want);
      end
   endtask

   function automatic int eff_of(input key_t k, input bit bad);
      int off;
      if (k.v || !k.en || bad) return 0;
      off = (k.raw * CS) % AW;
      return k.mode ? (AW - off) % AW : off;
   endfunction

   // A line just ended: schedule its replay, rotated by its own key.
   task automatic model_line_start();
      bit bad;
      int e, a;
      if (mdl_started) begin
         bad = (mdl_n != LW);
         e = eff_of(mdl_key, bad);
         if (bad) exp_le[slot + 1] = 1'b1;
         for (int k = 0; k < LW; k++) begin
            a = (k < AO) ? k : AO + ((k - AO + e) % AW);
            if (a < mdl_n) exp_out[slot + 2 + k] = mdl_buf[a];
            else exp_out.delete(slot + 2 + k);
         end
      end
      mdl_key = '{v, int'(raw), mode, en};
      mdl_n = 0;
      mdl_started = 1;
      mdl_starts++;
      if (mdl_starts == 2) dv_from = slot + 2;
   endtask

   // One word slot: compare outputs, drive inputs, update the model.
   task automatic step(input logic [DW-1:0] d, input bit hv, input bit rn);
      @(negedge clk);
      if (!reset_n) begin
         check("rst_data_out", data_out, 0);
         check("rst_data_valid", data_valid, 0);
         check("rst_length_err", length_err, 0);
      end else begin
         if (length_err) le_count++;
         if (exp_out.exists(slot)) begin
            check("data_out", data_out, exp_out[slot]);
            exp_out.delete(slot);
         end
         check("data_valid", data_valid, (dv_from >= 0 && slot >= dv_from) ? 1 : 0);
         check("length_err", length_err, exp_le.exists(slot) ? 1 : 0);
         while (probes.size() > 0 && probes[0].at == slot) begin
            check(probes[0].name, data_out, probes[0].want);
            void'(probes.pop_front());
         end
         if (slot - 2*LAT >= chain_lo && slot - 2*LAT < chain_hi)
            check("chain_roundtrip", out_b, hist[slot - 2*LAT]);
      end
      data_in = d;
      h = hv;
      reset_n = rn;
      h_b = h_d2;
      h_d2 = h_d1;
      h_d1 = hv;
      hist[slot] = d;
      if (!rn) begin
         exp_out.delete();
         exp_le.delete();
         probes.delete();
         mdl_started = 0;
         mdl_starts = 0;
         mdl_n = 0;
         dv_from = -1;
         mdl_prev_h = 0;
      end else begin
         if (hv && !mdl_prev_h) model_line_start();
         mdl_buf[(mdl_n < LW) ? mdl_n : LW - 1] = d;
         mdl_n++;
         mdl_prev_h = hv;
      end
      slot++;
   endtask

   task automatic send_line(input int len, input key_t k, input bit ramp, input bit jitter,
                            input int pk, input int pwant, input string pname);
      logic [DW-1:0] d;
      v = k.v; raw = k.raw[CW-1:0]; mode = k.mode; en = k.en;
      v_b = prev_key.v; raw_b = prev_key.raw[CW-1:0]; mode_b = ~prev_key.mode; en_b = prev_key.en;
      prev_key = k;
      if (pk >= 0) probes.push_back('{slot + LAT + pk, pwant, pname});
      for (int j = 0; j < len; j++) begin
         if (jitter && j == len / 2) begin
            raw = 8'($urandom);
            mode = ~mode;
         end
         d = ramp ? DW'(j % 1024) : DW'($urandom_range(0, 1023));
         step(d, j < HW, 1'b1);
      end
   endtask

   vec_t tbl [12];
   key_t kk;
   int   c0;

   initial begin
      tbl[0]  = '{'h80, 0, 1, 0,  276, 788, "r80_first_active"};
      tbl[1]  = '{'h80, 0, 1, 0, 1203, 691, "r80_k1203"};
      tbl[2]  = '{'h80, 0, 1, 0, 1204, 276, "r80_wrap"};
      tbl[3]  = '{'h80, 0, 1, 0,  100, 100, "r80_blanking"};
      tbl[4]  = '{'h80, 0, 1, 1,  276, 276, "vblank_bypass"};
      tbl[5]  = '{'hFF, 0, 1, 0,  276, 272, "rFF_first_active"};
      tbl[6]  = '{'hFF, 0, 1, 0,  696, 276, "rFF_wrap"};
      tbl[7]  = '{'h00, 0, 1, 0,  500, 500, "r00_identity"};
      tbl[8]  = '{'h80, 1, 1, 0,  276, 180, "r80_descramble"};
      tbl[9]  = '{'h80, 0, 0, 0,  800, 800, "disabled"};
      tbl[10] = '{'hFF, 1, 1, 0, 1715, 695, "rFF_desc_last"};
      tbl[11] = '{'hC0, 0, 1, 0, 1000, 328, "rC0_fold"};
      prev_key = '{0, 0, 0, 0};

      // reset state
      repeat (3) step('0, 1'b0, 1'b0);
      repeat (2) step('0, 1'b0, 1'b1);

      // directed ramp lines
      for (int i = 0; i < 12; i++) begin
         kk = '{tbl[i].v, tbl[i].raw, tbl[i].mode, tbl[i].en};
         send_line(LW, kk, 1'b1, 1'b0, tbl[i].k, tbl[i].want, tbl[i].name);
      end

      // scramble into descramble with random per-line keys
      chain_lo = slot;
      for (int i = 0; i < 8; i++) begin
         if (i == 5) chain_hi = slot;
         kk = '{($urandom_range(0, 7) == 0), int'($urandom_range(0, 255)), 1'b0, 1'b1};
         send_line(LW, kk, 1'b0, 1'b1, -1, 0, "");
      end

      // short line: one pulse, unrotated replay, next line rotates again
      c0 = le_count;
      kk = '{0, 'h80, 0, 1};
      send_line(1000, kk, 1'b1, 1'b0, -1, 0, "");
      send_line(LW, kk, 1'b1, 1'b0, 276, 788, "after_short_rotates");
      send_line(LW, kk, 1'b1, 1'b0, -1, 0, "");
      check("short_le_once", le_count - c0, 1);

      // long line: saturating write, pulse at the following line start
      c0 = le_count;
      send_line(LW + 20, kk, 1'b0, 1'b0, -1, 0, "");
      send_line(LW, kk, 1'b1, 1'b0, -1, 0, "");
      check("long_le_once", le_count - c0, 1);

      // reset mid-line, then restart from scratch
      for (int j = 0; j < 500; j++) step(DW'(j), j < HW, 1'b1);
      step('0, 1'b0, 1'b0);
      #1;
      check("rst_now_data_out", data_out, 0);
      check("rst_now_data_valid", data_valid, 0);
      step('0, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);
      for (int j = 0; j < 300; j++) step(DW'($urandom_range(0, 1023)), 1'b0, 1'b1);
      kk = '{0, 'hFF, 0, 1};
      send_line(LW, kk, 1'b1, 1'b0, -1, 0, "");
      send_line(LW, kk, 1'b1, 1'b0, 276, 272, "post_reset_rFF");
      send_line(LW, kk, 1'b1, 1'b0, -1, 0, "");
      repeat (4) step('0, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
